// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Load/store sequencer between the CPU MEM stage and the data-memory bus.
// Accepts one byte/halfword/word access, rejects misaligned ones without
// touching the bus, otherwise issues a word-aligned bus request with byte
// enables and lane-positioned store data, waits for the acknowledge (or a
// timeout) and returns zero/sign-extended load data. The pipeline is stalled
// for as long as a request is pending and not yet completed.
//
// Parameters
//   TIMEOUT_CYCLES  max request cycles without ack before abort (0 = never)
//
// Ports
//   Clk_I        clock, rising edge
//   Rst_N_I      synchronous active-low reset
//   Req_I        CPU access request, held with operands until Done_O
//   We_I         1 = store, 0 = load
//   Size_I       `EXT_M_8BIT / `EXT_M_16BIT / anything else = word
//   Signed_I     sign-extend byte/half loads
//   Addr_I       byte address
//   WData_I      right-justified store data
//   RData_O      registered extended load data
//   Done_O       one-cycle completion pulse
//   AdErr_O      misalignment flag (with Done_O)
//   BusErr_O     timeout flag (with Done_O)
//   Stall_O      Req_I & ~Done_O
//   Mem_Req_O    bus request
//   Mem_We_O     bus write
//   Mem_Addr_O   word-aligned bus address
//   Mem_Be_O     byte enables
//   Mem_WData_O  lane-positioned store data
//   Mem_RData_I  bus read data, valid with Mem_Ack_I
//   Mem_Ack_I    bus acknowledge
// ---------------------------------------------------------------------------

`ifndef EXT_M_8BIT
`define EXT_M_8BIT 2'b00
`endif
`ifndef EXT_M_16BIT
`define EXT_M_16BIT 2'b01
`endif

module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk_I,
    input  logic        Rst_N_I,
    input  logic        Req_I,
    input  logic        We_I,
    input  logic [1:0]  Size_I,
    input  logic        Signed_I,
    input  logic [31:0] Addr_I,
    input  logic [31:0] WData_I,
    output logic [31:0] RData_O,
    output logic        Done_O,
    output logic        AdErr_O,
    output logic        BusErr_O,
    output logic        Stall_O,
    output logic        Mem_Req_O,
    output logic        Mem_We_O,
    output logic [31:0] Mem_Addr_O,
    output logic [3:0]  Mem_Be_O,
    output logic [31:0] Mem_WData_O,
    input  logic [31:0] Mem_RData_I,
    input  logic        Mem_Ack_I
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The wait counter is compared against the last legal wait count, so a
    // timeout of N cycles keeps the request up for exactly N cycles.
    localparam bit          TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;

    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [1:0]  lat_a;
    logic        ad_err_q;
    logic        bus_err_q;
    logic [15:0] wait_cnt;
    logic [31:0] rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;

    logic        in_is_byte, in_is_half, in_misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] load_ext;
    logic [31:0] lane_shifted;
    logic        timed_out;

    assign in_is_byte    = (Size_I == `EXT_M_8BIT);
    assign in_is_half    = (Size_I == `EXT_M_16BIT);
    assign in_misaligned = (in_is_half & Addr_I[0]) |
                           (~in_is_byte & ~in_is_half & (|Addr_I[1:0]));

    assign timed_out = TIMEOUT_ON && (wait_cnt == TIMEOUT_LAST);

    // Byte enables and store data are computed from the live CPU operands so
    // they can be loaded into the bus registers on the accepting edge.
    always_comb begin
        be_in    = 4'b1111;
        wdata_in = WData_I;
        if (in_is_byte) begin
            be_in    = 4'b0001 << Addr_I[1:0];
            wdata_in = {24'h0, WData_I[7:0]} << {Addr_I[1:0], 3'b000};
        end else if (in_is_half) begin
            be_in    = Addr_I[1] ? 4'b1100 : 4'b0011;
            wdata_in = Addr_I[1] ? {WData_I[15:0], 16'h0}
                                 : {16'h0, WData_I[15:0]};
        end
    end

    // Load extraction works on the latched size/offset because Mem_RData_I
    // only arrives while in ACCESS.
    assign lane_shifted = Mem_RData_I >> {lat_a, 3'b000};

    always_comb begin
        load_ext = Mem_RData_I;
        if (lat_size == `EXT_M_8BIT) begin
            load_ext = {{24{lat_signed & lane_shifted[7]}}, lane_shifted[7:0]};
        end else if (lat_size == `EXT_M_16BIT) begin
            load_ext = {{16{lat_signed & lane_shifted[15]}}, lane_shifted[15:0]};
        end
    end

    // State register.
    always_ff @(posedge Clk_I) begin
        if (!Rst_N_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A misaligned request skips the bus entirely; an ack
    // in the final allowed cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (Req_I) begin
                    state_nxt = in_misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (Mem_Ack_I || timed_out) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latching, bus registers, wait counter, error flags and load
    // data capture. Bus registers are only reloaded for an aligned accept so
    // they stay stable for the whole ACCESS state.
    always_ff @(posedge Clk_I) begin
        if (!Rst_N_I) begin
            lat_we      <= 1'b0;
            lat_size    <= 2'b00;
            lat_signed  <= 1'b0;
            lat_a       <= 2'b00;
            ad_err_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            wait_cnt    <= 16'd0;
            rdata_q     <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Req_I) begin
                        lat_we     <= We_I;
                        lat_size   <= Size_I;
                        lat_signed <= Signed_I;
                        lat_a      <= Addr_I[1:0];
                        ad_err_q   <= in_misaligned;
                        bus_err_q  <= 1'b0;
                        wait_cnt   <= 16'd0;
                        if (!in_misaligned) begin
                            mem_we_q    <= We_I;
                            mem_addr_q  <= {Addr_I[31:2], 2'b00};
                            mem_be_q    <= be_in;
                            mem_wdata_q <= wdata_in;
                        end
                    end
                end
                ACCESS: begin
                    if (Mem_Ack_I) begin
                        if (!lat_we) begin
                            rdata_q <= load_ext;
                        end
                    end else if (timed_out) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Done_O      = (state == DONE);
    assign AdErr_O     = Done_O & ad_err_q;
    assign BusErr_O    = Done_O & bus_err_q;
    assign Stall_O     = Req_I & ~Done_O;
    assign Mem_Req_O   = (state == ACCESS);
    assign Mem_We_O    = mem_we_q;
    assign Mem_Addr_O  = mem_addr_q;
    assign Mem_Be_O    = mem_be_q;
    assign Mem_WData_O = mem_wdata_q;
    assign RData_O     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl with TIMEOUT_CYCLES = 4. A transaction
// model derives each access's expected cycle-by-cycle behaviour (request
// length, completion, error flags, bus lanes, extended load data) from byte
// counts and offsets; a compare process checks the DUT on every falling edge.
// ---------------------------------------------------------------------------

`ifndef EXT_M_8BIT
`define EXT_M_8BIT 2'b00
`endif
`ifndef EXT_M_16BIT
`define EXT_M_16BIT 2'b01
`endif

module tb_mem_access_ctrl;

    localparam int         TMO  = 4;
    localparam logic [1:0] SZ_B = `EXT_M_8BIT;
    localparam logic [1:0] SZ_H = `EXT_M_16BIT;
    localparam logic [1:0] SZ_W = 2'b11;

    logic        Clk_I;
    logic        Rst_N_I;
    logic        Req_I;
    logic        We_I;
    logic [1:0]  Size_I;
    logic        Signed_I;
    logic [31:0] Addr_I;
    logic [31:0] WData_I;
    logic [31:0] RData_O;
    logic        Done_O;
    logic        AdErr_O;
    logic        BusErr_O;
    logic        Stall_O;
    logic        Mem_Req_O;
    logic        Mem_We_O;
    logic [31:0] Mem_Addr_O;
    logic [3:0]  Mem_Be_O;
    logic [31:0] Mem_WData_O;
    logic [31:0] Mem_RData_I;
    logic        Mem_Ack_I;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk_I       (Clk_I),
        .Rst_N_I     (Rst_N_I),
        .Req_I       (Req_I),
        .We_I        (We_I),
        .Size_I      (Size_I),
        .Signed_I    (Signed_I),
        .Addr_I      (Addr_I),
        .WData_I     (WData_I),
        .RData_O     (RData_O),
        .Done_O      (Done_O),
        .AdErr_O     (AdErr_O),
        .BusErr_O    (BusErr_O),
        .Stall_O     (Stall_O),
        .Mem_Req_O   (Mem_Req_O),
        .Mem_We_O    (Mem_We_O),
        .Mem_Addr_O  (Mem_Addr_O),
        .Mem_Be_O    (Mem_Be_O),
        .Mem_WData_O (Mem_WData_O),
        .Mem_RData_I (Mem_RData_I),
        .Mem_Ack_I   (Mem_Ack_I)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected per-cycle outputs, written by the stimulus, read by the
    // compare process.
    bit          chk_en = 1'b0;
    bit          chk_wd = 1'b0;
    logic        exp_req, exp_done, exp_stall, exp_aderr, exp_buserr, exp_we;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] model_rdata = 32'h0;

    initial begin
        Clk_I = 1'b0;
        forever #5 Clk_I = ~Clk_I;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: access width in bytes from the size code.
    function automatic int nbytes(input logic [1:0] size);
        if (size == SZ_B) return 1;
        if (size == SZ_H) return 2;
        return 4;
    endfunction

    // Misaligned whenever the byte offset is not a multiple of the width.
    function automatic bit model_misaligned(input logic [1:0] size, input logic [31:0] addr);
        return (int'(addr[1:0]) % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        logic [7:0] m;
        m = 8'((1 << nbytes(size)) - 1);
        m = m << int'(addr[1:0]);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        logic [63:0] v;
        v = 64'(wdata) & ((64'd1 << (8 * nbytes(size))) - 64'd1);
        v = v << (8 * int'(addr[1:0]));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] v, mask;
        int          n;
        n    = nbytes(size);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (64'(data) >> (8 * int'(addr[1:0]))) & mask;
        if (sgn && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: checks every cycle while a modelled sequence runs.
    always @(negedge Clk_I) begin
        if (chk_en) begin
            checkOutput("done",    32'(Done_O),    32'(exp_done));
            checkOutput("mem_req", 32'(Mem_Req_O), 32'(exp_req));
            checkOutput("stall",   32'(Stall_O),   32'(exp_stall));
            checkOutput("rdata",   RData_O,        exp_rdata);
            if (exp_done) begin
                checkOutput("aderr",  32'(AdErr_O),  32'(exp_aderr));
                checkOutput("buserr", 32'(BusErr_O), 32'(exp_buserr));
            end
            if (exp_req) begin
                checkOutput("mem_addr", Mem_Addr_O,    exp_addr);
                checkOutput("mem_be",   32'(Mem_Be_O), 32'(exp_be));
                checkOutput("mem_we",   32'(Mem_We_O), 32'(exp_we));
                if (chk_wd) checkOutput("mem_wdata", Mem_WData_O, exp_wdata);
            end
        end
    end

    // One complete access. ack_after = number of wait cycles before the
    // bus acknowledges; negative means the bus never answers. Called and
    // returns just after a rising edge with the DUT idle.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] bus_data, input int ack_after);
        bit          mis, tout;
        int          n_req;
        logic [31:0] new_rd;
        mis    = model_misaligned(size, addr);
        tout   = !mis && (ack_after < 0 || ack_after >= TMO);
        n_req  = mis ? 0 : (tout ? TMO : ack_after + 1);
        new_rd = (!we && !mis && !tout) ? model_load(size, sgn, addr, bus_data) : model_rdata;

        Req_I = 1'b1; We_I = we; Size_I = size; Signed_I = sgn;
        Addr_I = addr; WData_I = wdata;
        Mem_Ack_I = 1'b0; Mem_RData_I = 32'hDEAD_BEEF;
        exp_req = 1'b0; exp_done = 1'b0; exp_stall = 1'b1;
        exp_aderr = 1'b0; exp_buserr = 1'b0; exp_rdata = model_rdata;
        exp_addr = {addr[31:2], 2'b00}; exp_be = model_be(size, addr);
        exp_wdata = model_wdata(size, addr, wdata); exp_we = we; chk_wd = we;
        chk_en = 1'b1;

        for (int k = 1; k <= n_req; k++) begin
            @(posedge Clk_I); #1;
            exp_req     = 1'b1;
            Mem_Ack_I   = (ack_after == k - 1);
            Mem_RData_I = Mem_Ack_I ? bus_data : 32'hDEAD_BEEF;
        end

        // Completion cycle; a stray ack here must be ignored.
        @(posedge Clk_I); #1;
        Mem_Ack_I = 1'b1; Mem_RData_I = 32'h5A5A_5A5A;
        exp_req = 1'b0; exp_done = 1'b1; exp_stall = 1'b0;
        exp_aderr = mis; exp_buserr = tout;
        exp_rdata = new_rd; model_rdata = new_rd;
        #6 Req_I = 1'b0;

        // Idle cycle, stray ack still present and ignored.
        @(posedge Clk_I); #1;
        exp_done = 1'b0; exp_stall = 1'b0; exp_aderr = 1'b0; exp_buserr = 1'b0;
        @(posedge Clk_I); #1;
        Mem_Ack_I = 1'b0;
    endtask

    initial begin
        Rst_N_I = 1'b0; Req_I = 1'b0; We_I = 1'b0; Size_I = SZ_W; Signed_I = 1'b0;
        Addr_I = 32'h0; WData_I = 32'h0; Mem_RData_I = 32'h0; Mem_Ack_I = 1'b0;
        exp_req = 1'b0; exp_done = 1'b0; exp_stall = 1'b0; exp_aderr = 1'b0;
        exp_buserr = 1'b0; exp_we = 1'b0; exp_rdata = 32'h0; exp_addr = 32'h0;
        exp_wdata = 32'h0; exp_be = 4'h0;

        // Reset values.
        @(posedge Clk_I); #1;
        #4;
        checkOutput("rst_rdata",  RData_O,           32'h0);
        checkOutput("rst_done",   32'(Done_O),       32'h0);
        checkOutput("rst_aderr",  32'(AdErr_O),      32'h0);
        checkOutput("rst_buserr", 32'(BusErr_O),     32'h0);
        checkOutput("rst_memreq", 32'(Mem_Req_O),    32'h0);
        checkOutput("rst_memwe",  32'(Mem_We_O),     32'h0);
        checkOutput("rst_addr",   Mem_Addr_O,        32'h0);
        checkOutput("rst_be",     32'(Mem_Be_O),     32'h0);
        checkOutput("rst_wdata",  Mem_WData_O,       32'h0);
        checkOutput("rst_stall0", 32'(Stall_O),      32'h0);
        @(posedge Clk_I); #1;
        Req_I = 1'b1;
        #4;
        checkOutput("rst_stall1", 32'(Stall_O),   32'h1);
        checkOutput("rst_req_hi", 32'(Mem_Req_O), 32'h0);
        @(posedge Clk_I); #1;
        Req_I = 1'b0; Rst_N_I = 1'b1;
        @(posedge Clk_I); #1;

        // Model pins.
        checkOutput("pin_lb",     model_load(SZ_B, 1'b1, 32'h103, 32'h80AA_5511), 32'hFFFF_FF80);
        checkOutput("pin_be_sh",  32'(model_be(SZ_H, 32'h202)), 32'h0000_000C);
        checkOutput("pin_wd_sh",  model_wdata(SZ_H, 32'h202, 32'h1234_ABCD), 32'hABCD_0000);
        checkOutput("pin_mis_lw", 32'(model_misaligned(SZ_W, 32'h106)), 32'h1);

        // lb / lbu at 0x103.
        applyStimulus(1'b0, SZ_B, 1'b1, 32'h0000_0103, 32'h0, 32'h80AA_5511, 0);
        checkOutput("lb_rdata", RData_O, 32'hFFFF_FF80);
        applyStimulus(1'b0, SZ_B, 1'b0, 32'h0000_0103, 32'h0, 32'h80AA_5511, 0);
        checkOutput("lbu_rdata", RData_O, 32'h0000_0080);

        // sh at 0x202, load data untouched.
        applyStimulus(1'b1, SZ_H, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0);
        checkOutput("sh_rdata", RData_O, 32'h0000_0080);

        // Misaligned lw.
        applyStimulus(1'b0, SZ_W, 1'b0, 32'h0000_0106, 32'h0, 32'h0, 0);

        // lhu with three wait states (ack on the last allowed cycle).
        applyStimulus(1'b0, SZ_H, 1'b0, 32'h0000_0300, 32'h0, 32'h0000_F00D, 3);
        checkOutput("lhu_rdata", RData_O, 32'h0000_F00D);

        // sw timeout, then sw acked on the 4th cycle.
        applyStimulus(1'b1, SZ_W, 1'b0, 32'h0000_0404, 32'hCAFE_0001, 32'h0, -1);
        checkOutput("tmo_rdata", RData_O, 32'h0000_F00D);
        applyStimulus(1'b1, SZ_W, 1'b0, 32'h0000_0408, 32'hCAFE_0002, 32'h0, 3);

        // Further lanes and sizes.
        applyStimulus(1'b0, SZ_H, 1'b1, 32'h0000_0302, 32'h0, 32'h8001_1234, 1);
        checkOutput("lh_rdata", RData_O, 32'hFFFF_8001);
        applyStimulus(1'b0, SZ_B, 1'b1, 32'h0000_0101, 32'h0, 32'h0000_7F00, 2);
        checkOutput("lb1_rdata", RData_O, 32'h0000_007F);
        applyStimulus(1'b1, SZ_B, 1'b0, 32'h0000_0102, 32'h0000_00EE, 32'h0, 0);
        applyStimulus(1'b0, SZ_H, 1'b0, 32'h0000_0301, 32'h0, 32'h0, 0);
        applyStimulus(1'b0, SZ_W, 1'b0, 32'h0000_040C, 32'h0, 32'hCAFE_BABE, 1);
        checkOutput("lw_rdata", RData_O, 32'hCAFE_BABE);

        // Reset during the 2nd wait cycle of a load.
        chk_en = 1'b0;
        Req_I = 1'b1; We_I = 1'b0; Size_I = SZ_W; Signed_I = 1'b0;
        Addr_I = 32'h0000_0500; Mem_Ack_I = 1'b0;
        @(posedge Clk_I); #1;
        @(posedge Clk_I); #1;
        Rst_N_I = 1'b0;
        @(posedge Clk_I); #1;
        Req_I = 1'b0; Rst_N_I = 1'b1;
        #4;
        checkOutput("rmid_memreq", 32'(Mem_Req_O), 32'h0);
        checkOutput("rmid_rdata",  RData_O,        32'h0);
        checkOutput("rmid_done",   32'(Done_O),    32'h0);
        @(posedge Clk_I); #1;
        #4;
        checkOutput("rmid_done2",  32'(Done_O),    32'h0);
        @(posedge Clk_I); #1;
        model_rdata = 32'h0;

        applyStimulus(1'b0, SZ_W, 1'b0, 32'h0000_0400, 32'h0, 32'h1122_3344, 0);
        checkOutput("post_rst_lw", RData_O, 32'h1122_3344);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
